// File: rtl/log_perf_ctrl_if.sv
// Dump/clean request handshake between a requester and log_perf_ctrl.
// A request is taken when valid and ready are both high at a rising edge.
interface log_perf_ctrl_if;
    logic ext_dump_valid;
    logic ext_dump_ready;
    logic ext_clean_valid;
    logic ext_clean_ready;

    modport master (
        output ext_dump_valid,
        output ext_clean_valid,
        input  ext_dump_ready,
        input  ext_clean_ready
    );

    modport slave (
        input  ext_dump_valid,
        input  ext_clean_valid,
        output ext_dump_ready,
        output ext_clean_ready
    );
endinterface

// File: rtl/log_perf_ctrl.sv
// Perf-log controller: free-running timer, log window, periodic and
// requested dump/clean strobes sequenced by a small FSM.
module log_perf_ctrl #(
    parameter bit          CLEAN_AFTER_DUMP = 1'b1,
    parameter int unsigned GAP_CYCLES       = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [63:0]          log_begin,
    input  logic [63:0]          log_end,
    input  logic [31:0]          dump_period,
    log_perf_ctrl_if.slave       ext,
    output logic [63:0]          timer,
    output logic                 logEnable,
    output logic                 clean,
    output logic                 dump,
    output logic                 busy,
    output logic [31:0]          dump_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DUMP,
        S_CLEAN,
        S_GAP
    } state_t;

    localparam logic [3:0] LP_GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_timer;
    logic [31:0] r_pcnt;
    logic [31:0] r_dump_cnt;
    logic [3:0]  r_gap;
    logic        r_pend_per;
    logic        r_pend_dump;
    logic        r_pend_clean;

    logic        w_per_evt;
    logic        w_acc_dump;
    logic        w_acc_clean;
    logic        w_any_dump;
    logic        w_any_clean;
    logic        w_dump;
    logic        w_clean;

    assign w_per_evt   = (dump_period != 32'd0) &&
                         (r_pcnt >= dump_period - 32'd1);
    assign w_acc_dump  = ext.ext_dump_valid & ~r_pend_dump;
    assign w_acc_clean = ext.ext_clean_valid & ~r_pend_clean;

    // Incoming sets are looked at directly so a fresh request strobes next cycle.
    assign w_any_dump  = r_pend_per | w_per_evt | r_pend_dump | w_acc_dump;
    assign w_any_clean = r_pend_clean | w_acc_clean;

    always_comb begin
        w_state_nxt = r_state;
        w_dump      = 1'b0;
        w_clean     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_dump) begin
                    w_state_nxt = S_DUMP;
                end else if (w_any_clean) begin
                    w_state_nxt = S_CLEAN;
                end
            end
            S_DUMP: begin
                w_dump      = 1'b1;
                w_state_nxt = CLEAN_AFTER_DUMP ? S_CLEAN : S_GAP;
            end
            S_CLEAN: begin
                w_clean     = 1'b1;
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_gap == LP_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Set terms are OR'd after the clear so a same-cycle set survives.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_timer      <= 64'd0;
            r_pcnt       <= 32'd0;
            r_dump_cnt   <= 32'd0;
            r_gap        <= 4'd0;
            r_pend_per   <= 1'b0;
            r_pend_dump  <= 1'b0;
            r_pend_clean <= 1'b0;
        end else begin
            r_timer      <= r_timer + 64'd1;
            r_pcnt       <= (dump_period == 32'd0 || w_per_evt) ?
                            32'd0 : r_pcnt + 32'd1;
            r_pend_per   <= w_per_evt | (r_pend_per & ~w_dump);
            r_pend_dump  <= w_acc_dump | (r_pend_dump & ~w_dump);
            r_pend_clean <= w_acc_clean | (r_pend_clean & ~w_clean);
            r_gap        <= (r_state == S_GAP && r_gap != LP_GAP_LAST) ?
                            r_gap + 4'd1 : 4'd0;
            if (w_dump) begin
                r_dump_cnt <= r_dump_cnt + 32'd1;
            end
        end
    end

    assign timer               = r_timer;
    assign logEnable           = (r_timer >= log_begin) && (r_timer < log_end);
    assign dump                = w_dump;
    assign clean               = w_clean;
    assign busy                = (r_state != S_IDLE);
    assign dump_count          = r_dump_cnt;
    assign ext.ext_dump_ready  = ~r_pend_dump;
    assign ext.ext_clean_ready = ~r_pend_clean;

endmodule
